// File: rtl/rsa_block_packer.sv
// rtl/rsa_block_packer.sv - packs a byte stream into (K-1)-bit blocks for rsa_encoder
// and returns each K-bit ciphertext on a valid/ready output port.
module rsa_block_packer #(
  parameter int K       = 12,
  parameter int TIMEOUT = 4095
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic         enc_start,
  output logic [K-1:0] enc_data_in,
  input  logic         enc_done,
  input  logic [K-1:0] enc_data_out,
  output logic [K-1:0] out_data,
  output logic         out_valid,
  output logic         out_last,
  input  logic         out_ready,
  output logic         timeout_err
);

  localparam int B  = K - 1;
  localparam int W  = B + 7;
  localparam int CW = $clog2(W + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_FILL, S_ENC, S_OUT} state_t;

  state_t         state, state_n;
  logic [W-1:0]   bit_buf;
  logic [CW-1:0]  cnt;
  logic           flush;
  logic           last_pend;
  logic [TW-1:0]  wdog;

  logic           accept;
  logic           have_block;
  logic           pad_block;
  logic           wdog_expired;
  logic [W-1:0]   byte_ext;

  assign accept       = in_valid & in_ready;
  assign have_block   = (cnt >= CW'(B));
  assign pad_block    = flush & (cnt != '0);
  assign wdog_expired = (wdog == TW'(TIMEOUT - 1));
  assign byte_ext     = {in_data, {(W-8){1'b0}}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FILL;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_FILL: if (have_block || pad_block) state_n = S_ENC;
      S_ENC: begin
        if (enc_done)          state_n = S_OUT;
        else if (wdog_expired) state_n = S_FILL;
      end
      S_OUT:  if (out_ready) state_n = S_FILL;
      default: state_n = S_FILL;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_FILL) && (cnt < CW'(B)) && !flush;
    out_valid = (state == S_OUT);
  end

  // Bits below cnt in bit_buf are always zero, so appending is a plain OR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_buf     <= '0;
      cnt         <= '0;
      flush       <= 1'b0;
      last_pend   <= 1'b0;
      wdog        <= '0;
      enc_start   <= 1'b0;
      enc_data_in <= '0;
      out_data    <= '0;
      out_last    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_FILL: begin
          if (accept) begin
            bit_buf <= bit_buf | (byte_ext >> cnt);
            cnt     <= cnt + CW'(8);
            if (in_last) flush <= 1'b1;
          end else if (have_block) begin
            enc_data_in <= {1'b0, bit_buf[W-1 -: B]};
            bit_buf     <= bit_buf << B;
            cnt         <= cnt - CW'(B);
            last_pend   <= flush && (cnt == CW'(B));
            enc_start   <= 1'b1;
            wdog        <= '0;
          end else if (pad_block) begin
            enc_data_in <= {1'b0, bit_buf[W-1 -: B]};
            bit_buf     <= '0;
            cnt         <= '0;
            last_pend   <= 1'b1;
            enc_start   <= 1'b1;
            wdog        <= '0;
          end else if (flush) begin
            flush <= 1'b0;
          end
        end
        S_ENC: begin
          if (enc_done) begin
            out_data  <= enc_data_out;
            out_last  <= last_pend;
            enc_start <= 1'b0;
          end else if (wdog_expired) begin
            timeout_err <= 1'b1;
            enc_start   <= 1'b0;
          end else begin
            wdog <= wdog + TW'(1);
          end
        end
        S_OUT: begin
          if (out_ready && out_last) flush <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_block_packer.sv
// tb/tb_rsa_block_packer.sv - directed self-checking bench for rsa_block_packer
// with a behavioural encoder stub (done 20 cycles after start, data ^ 12'hFFF).
module tb_rsa_block_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid, in_last, in_ready;
  logic        enc_start, enc_done;
  logic [11:0] enc_data_in, enc_data_out, out_data;
  logic        out_valid, out_last, out_ready, timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic        stub_en;
  logic        start_q;
  int          stub_cnt;
  logic        mon_start_prev = 1'b0;
  int          ov_cycles = 0;
  logic [11:0] enc_q[$];
  logic [11:0] out_q[$];
  logic        last_q[$];

  rsa_block_packer #(.K(12), .TIMEOUT(100)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .enc_start(enc_start), .enc_data_in(enc_data_in),
    .enc_done(enc_done), .enc_data_out(enc_data_out),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q      <= 1'b0;
      stub_cnt     <= 0;
      enc_done     <= 1'b0;
      enc_data_out <= '0;
    end else begin
      start_q  <= enc_start;
      enc_done <= 1'b0;
      if (enc_start && !start_q) begin
        stub_cnt <= 1;
      end else if (stub_cnt != 0) begin
        if (stub_cnt == 19) begin
          stub_cnt <= 0;
          if (stub_en) begin
            enc_done     <= 1'b1;
            enc_data_out <= enc_data_in ^ 12'hFFF;
          end
        end else begin
          stub_cnt <= stub_cnt + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (enc_start && !mon_start_prev) enc_q.push_back(enc_data_in);
    mon_start_prev <= enc_start;
    if (out_valid) ov_cycles <= ov_cycles + 1;
    if (out_valid && out_ready) begin
      out_q.push_back(out_data);
      last_q.push_back(out_last);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    int n;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_eq("send_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_outs(input string tag, input int n);
    int t;
    t = 0;
    while (out_q.size() < n && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check_eq(tag, out_q.size(), n);
  endtask

  task automatic clear_q();
    enc_q.delete();
    out_q.delete();
    last_q.delete();
  endtask

  initial begin
    int t, hi, bad;
    logic [11:0] held;
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1; stub_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_enc_start", enc_start, 0);
    check_eq("rst_enc_data_in", enc_data_in, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_timeout_err", timeout_err, 0);

    // Three bytes: two full blocks and one padded final block
    @(posedge clk); #1;
    clear_q();
    send(8'hAB, 1'b0);
    send(8'hCD, 1'b0);
    send(8'hEF, 1'b1);
    wait_outs("abc_count", 3);
    check_eq("abc_enc0", enc_q[0], 12'h55E);
    check_eq("abc_enc1", enc_q[1], 12'h37B);
    check_eq("abc_enc2", enc_q[2], 12'h600);
    check_eq("abc_out0", out_q[0], 12'hAA1);
    check_eq("abc_out1", out_q[1], 12'hC84);
    check_eq("abc_out2", out_q[2], 12'h9FF);
    check_eq("abc_last0", last_q[0], 0);
    check_eq("abc_last1", last_q[1], 0);
    check_eq("abc_last2", last_q[2], 1);

    // 88 bits: exactly eight blocks, no padded ninth
    @(posedge clk); #1;
    clear_q();
    for (int i = 0; i < 11; i++) send(8'hFF, i == 10);
    wait_outs("b88_count", 8);
    repeat (60) @(negedge clk);
    check_eq("b88_no_extra_out", out_q.size(), 8);
    check_eq("b88_no_extra_enc", enc_q.size(), 8);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (enc_q[i] !== 12'h7FF || out_q[i] !== 12'h800 || last_q[i] !== (i == 7)) bad++;
    end
    check_eq("b88_blocks", bad, 0);
    check_eq("b88_in_ready", in_ready, 1);

    // Sink stalls for 50 cycles; single byte 0x01 is the payload
    @(posedge clk); #1;
    clear_q();
    out_ready = 1'b0;
    send(8'h01, 1'b1);
    t = 0;
    while (!out_valid && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check_eq("stall_reached_out", out_valid, 1);
    held = out_data;
    check_eq("stall_out_data", held, 12'hFF7);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0 || enc_start !== 1'b0) bad++;
    end
    check_eq("stall_stable", bad, 0);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_outs("one_count", 1);
    check_eq("one_enc", enc_q[0], 12'h008);
    check_eq("one_out", out_q[0], 12'hFF7);
    check_eq("one_last", last_q[0], 1);
    check_eq("one_enc_count", enc_q.size(), 1);

    // Encoder never answers: watchdog fires after 100 cycles
    @(posedge clk); #1;
    clear_q();
    stub_en = 1'b0;
    ov_cycles = 0;
    send(8'h80, 1'b1);
    t = 0;
    while (!enc_start && t < 200) begin
      @(negedge clk);
      t++;
    end
    hi = 0;
    while (enc_start && hi < 400) begin
      hi++;
      @(negedge clk);
    end
    check_eq("to_start_width", hi, 100);
    check_eq("to_err", timeout_err, 1);
    repeat (10) @(negedge clk);
    check_eq("to_no_out_valid", ov_cycles, 0);
    check_eq("to_in_ready", in_ready, 1);

    // Reset while a block is in the encoder
    stub_en = 1'b1;
    @(posedge clk); #1;
    send(8'hC3, 1'b1);
    t = 0;
    while (!enc_start && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("rmid_enc_start", enc_start, 0);
    check_eq("rmid_out_valid", out_valid, 0);
    check_eq("rmid_in_ready", in_ready, 1);
    check_eq("rmid_timeout_err", timeout_err, 0);
    @(posedge clk); #1 rst = 1'b0;
    clear_q();
    send(8'h80, 1'b1);
    wait_outs("r80_count", 1);
    check_eq("r80_enc", enc_q[0], 12'h400);
    check_eq("r80_out", out_q[0], 12'hBFF);
    check_eq("r80_last", last_q[0], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
